gba_rom_loader: RTL

Receives the HPS ioctl byte stream during a cartridge download and packs it into 16-bit little-endian words. It issues each word to the SDRAM controller as a write request with an acknowledge, and throttles the HPS with `ioctl_wait`. It sits between `hps_io` and `sdram`. It also parses the GBA cartridge header (game code, fixed byte, complement check) and reports ROM size and address mask to the core.

---
 rtl/gba_rom_loader_pkg.sv | 24 ++
 rtl/gba_rom_loader_if.sv | 26 ++
 rtl/gba_rom_loader_header_check.sv | 56 +++++
 rtl/gba_rom_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gba_rom_loader_pkg.sv
// Shared types and GBA cartridge header constants for the ROM loader.
package gba_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    localparam int unsigned HDR_CHK_START = 32'hA0;
    localparam int unsigned HDR_CHK_END   = 32'hBC;
    localparam int unsigned HDR_CHK       = 32'hBD;
    localparam int unsigned HDR_CODE      = 32'hAC;
    localparam int unsigned HDR_FIXED     = 32'hB2;
    localparam logic [7:0]  HDR_FIXED_VAL = 8'h96;
    localparam logic [7:0]  HDR_CHK_BIAS  = 8'h19;

    // Complement byte the cartridge must carry at HDR_CHK for a given header sum.
    function automatic logic [7:0] hdr_chk_expect(input logic [7:0] sum);
        return 8'h00 - sum - HDR_CHK_BIAS;
    endfunction

endpackage

// File: rtl/gba_rom_loader_if.sv
// HPS ioctl byte stream plus SDRAM write-request bus seen by the ROM loader.
interface gba_rom_loader_if #(
    parameter int ADDR_W = 25
);
    // ioctl_wr is a one-cycle byte strobe, paused by the host while ioctl_wait=1.
    // mem_we_req is a level held with mem_addr/mem_din stable until a one-cycle
    // mem_ack; an ack while mem_we_req=0 carries no meaning.
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic [ADDR_W-2:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_we_req;
    logic              mem_ack;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_dout, mem_ack,
        output ioctl_wait, mem_addr, mem_din, mem_we_req
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_dout, mem_ack,
        input  ioctl_wait, mem_addr, mem_din, mem_we_req
    );
endinterface

// File: rtl/gba_rom_loader_header_check.sv
// Watches the download byte stream and extracts the GBA game code and header validity.
module gba_header_check
    import gba_loader_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data_i,
    input  logic [ADDR_W-1:0] offset_i,
    input  logic              strobe_i,
    input  logic              clear_i,
    output logic [31:0]       game_code,
    output logic              hdr_ok_raw
);
    logic [7:0]  sum_q;
    logic [31:0] code_q;
    logic        fixed_ok_q;
    logic        chk_ok_q;
    logic        in_sum;
    logic        in_code;

    assign in_sum  = (offset_i >= ADDR_W'(HDR_CHK_START)) && (offset_i <= ADDR_W'(HDR_CHK_END));
    assign in_code = offset_i[ADDR_W-1:2] == (ADDR_W-2)'(HDR_CODE >> 2);

    // The complement byte follows the summed range, so sum_q is complete when it arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q      <= '0;
            code_q     <= '0;
            fixed_ok_q <= 1'b0;
            chk_ok_q   <= 1'b0;
        end else if (clear_i) begin
            sum_q      <= '0;
            code_q     <= '0;
            fixed_ok_q <= 1'b0;
            chk_ok_q   <= 1'b0;
        end else if (strobe_i) begin
            if (in_sum) begin
                sum_q <= sum_q + data_i;
            end
            if (in_code) begin
                code_q[{offset_i[1:0], 3'b000} +: 8] <= data_i;
            end
            if (offset_i == ADDR_W'(HDR_FIXED)) begin
                fixed_ok_q <= (data_i == HDR_FIXED_VAL);
            end
            if (offset_i == ADDR_W'(HDR_CHK)) begin
                chk_ok_q <= (data_i == hdr_chk_expect(sum_q));
            end
        end
    end

    assign game_code  = code_q;
    assign hdr_ok_raw = fixed_ok_q && chk_ok_q;
endmodule

// File: rtl/gba_rom_loader.sv
// Packs the HPS download byte stream into 16-bit little-endian SDRAM writes and
// reports ROM size, address mask and header status at the end of the load.
module gba_rom_loader
    import gba_loader_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    gba_rom_loader_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   rom_bytes,
    output logic [ADDR_W-1:0] rom_mask,
    output logic [31:0]       game_code,
    output logic              hdr_ok,
    output logic              overrun,
    output loader_state_t     state_o
);
    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic [7:0]        lo_q, lo_d;
    logic              lo_vld_q, lo_vld_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [15:0]       din_q, din_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W:0]   rom_bytes_q, rom_bytes_d;
    logic [ADDR_W-1:0] rom_mask_q, rom_mask_d;
    logic              hdr_ok_q, hdr_ok_d;

    logic              slot_free;
    logic              hdr_strobe;
    logic              hdr_clear;
    logic              hdr_ok_raw;
    logic [ADDR_W:0]   bytes_sel;
    logic [ADDR_W-1:0] bytes_m1;
    logic [ADDR_W-1:0] mask_sel;

    // Once the counter has wrapped the length is pinned at 2^ADDR_W.
    always_comb begin
        bytes_sel = wrap_q ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, cnt_q};
        bytes_m1  = wrap_q ? {ADDR_W{1'b1}} : (cnt_q - 1'b1);
        mask_sel  = '0;
        if (wrap_q || (cnt_q != '0)) begin
            for (int i = 0; i < ADDR_W; i++) begin
                mask_sel[i] = |(bytes_m1 >> i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wrap_d      = wrap_q;
        lo_d        = lo_q;
        lo_vld_d    = lo_vld_q;
        pend_d      = pend_q;
        addr_d      = addr_q;
        din_d       = din_q;
        overrun_d   = overrun_q;
        rom_bytes_d = rom_bytes_q;
        rom_mask_d  = rom_mask_q;
        hdr_ok_d    = hdr_ok_q;
        hdr_strobe  = 1'b0;
        hdr_clear   = 1'b0;

        // An ack in this cycle frees the slot so a new word can follow with no gap.
        slot_free = !pend_q || bus.mem_ack;
        if (pend_q && bus.mem_ack) begin
            pend_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.ioctl_download) begin
                    state_d     = ST_LOAD;
                    cnt_d       = '0;
                    wrap_d      = 1'b0;
                    lo_vld_d    = 1'b0;
                    overrun_d   = 1'b0;
                    rom_bytes_d = '0;
                    rom_mask_d  = '0;
                    hdr_ok_d    = 1'b0;
                    hdr_clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.ioctl_wr) begin
                    hdr_strobe = !wrap_q;
                    cnt_d      = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        wrap_d = 1'b1;
                    end
                    if (!cnt_q[0]) begin
                        lo_d     = bus.ioctl_dout;
                        lo_vld_d = 1'b1;
                    end else begin
                        lo_vld_d = 1'b0;
                        if (slot_free) begin
                            pend_d = 1'b1;
                            addr_d = cnt_q[ADDR_W-1:1];
                            din_d  = {bus.ioctl_dout, lo_q};
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                if (!bus.ioctl_download) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (lo_vld_q) begin
                    if (slot_free) begin
                        pend_d   = 1'b1;
                        addr_d   = cnt_q[ADDR_W-1:1];
                        din_d    = {8'hFF, lo_q};
                        lo_vld_d = 1'b0;
                    end
                end else if (!pend_q) begin
                    state_d     = ST_DONE;
                    rom_bytes_d = bytes_sel;
                    rom_mask_d  = mask_sel;
                    hdr_ok_d    = hdr_ok_raw;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            lo_q        <= '0;
            lo_vld_q    <= 1'b0;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            overrun_q   <= 1'b0;
            rom_bytes_q <= '0;
            rom_mask_q  <= '0;
            hdr_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            lo_q        <= lo_d;
            lo_vld_q    <= lo_vld_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            overrun_q   <= overrun_d;
            rom_bytes_q <= rom_bytes_d;
            rom_mask_q  <= rom_mask_d;
            hdr_ok_q    <= hdr_ok_d;
        end
    end

    gba_header_check #(.ADDR_W(ADDR_W)) u_hdr (
        .clk        (clk_sys),
        .rst        (reset),
        .data_i     (bus.ioctl_dout),
        .offset_i   (cnt_q),
        .strobe_i   (hdr_strobe),
        .clear_i    (hdr_clear),
        .game_code  (game_code),
        .hdr_ok_raw (hdr_ok_raw)
    );

    assign bus.ioctl_wait = pend_q;
    assign bus.mem_we_req = pend_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_din    = din_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign rom_bytes      = rom_bytes_q;
    assign rom_mask       = rom_mask_q;
    assign hdr_ok         = hdr_ok_q;
    assign overrun        = overrun_q;
    assign state_o        = state_q;
endmodule
